// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory write (loader) and read (fetch) paths.
// Byte-lane constants fix the big-endian order used by both sides.
package imem_pkg;

  localparam int IMEM_BYTES     = 512;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;

  // Lane n of a word goes to byte address A+n; lane 0 is the most significant byte.
  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    WR0    = 3'd2,
    WR1    = 3'd3,
    WR2    = 3'd4,
    WR3    = 3'd5,
    DONE   = 3'd6
  } loader_state_e;

  // LSB position inside a 32-bit word of the byte stored at offset 'lane'.
  function automatic logic [4:0] lane_lsb(input logic [1:0] lane);
    return 5'((BYTES_PER_WORD - 1 - int'(lane)) * BYTE_W);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Loads 32-bit instruction words into the byte-wide instruction memory, big-endian,
// one byte per cycle, holding the fetch stage while a load is in progress.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              wrapped
);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [31:0]       word_q, word_d;
  logic              wrapped_q, wrapped_d;
  logic [1:0]        lane;
  logic              wr_active;
  logic [4:0]        lane_pos;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      word_q      <= '0;
      wrapped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      word_q      <= word_d;
      wrapped_q   <= wrapped_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    word_d      = word_q;
    wrapped_d   = wrapped_q;
    lane        = LANE_B0;
    wr_active   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = {base_addr[ADDR_W-1:2], 2'b00};
          remaining_d = word_count;
          wrapped_d   = 1'b0;
          state_d     = (word_count == '0) ? DONE : ACCEPT;
        end
      end
      ACCEPT: begin
        if (in_valid) begin
          word_d  = in_data;
          state_d = WR0;
        end
      end
      WR0: begin
        wr_active = 1'b1;
        lane      = LANE_B0;
        state_d   = WR1;
      end
      WR1: begin
        wr_active = 1'b1;
        lane      = LANE_B1;
        state_d   = WR2;
      end
      WR2: begin
        wr_active = 1'b1;
        lane      = LANE_B2;
        state_d   = WR3;
      end
      WR3: begin
        wr_active = 1'b1;
        lane      = LANE_B3;
        if (remaining_q != '0) begin
          remaining_d = remaining_q - 1'b1;
        end
        state_d = (remaining_q <= CNT_W'(1)) ? DONE : ACCEPT;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Every byte write advances the address; crossing the top of memory is recorded.
    if (wr_active) begin
      addr_d = addr_q + 1'b1;
      if (&addr_q) begin
        wrapped_d = 1'b1;
      end
    end
  end

  assign lane_pos  = lane_lsb(lane);
  assign in_ready  = (state_q == ACCEPT);
  assign mem_we    = wr_active;
  assign mem_addr  = addr_q;
  assign mem_wdata = wr_active ? word_q[lane_pos +: BYTE_W] : 8'h00;
  assign busy      = (state_q != IDLE);
  assign cpu_hold  = busy;
  assign done      = (state_q == DONE);
  assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte order, handshake timing, wrap, reset and edge requests.
module tb_imem_loader;

  localparam int ADDR_W = 9;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              cpu_hold;
  logic              done;
  logic              wrapped;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:511];
  bit         written [0:511];

  logic [31:0] w3 [0:2];

  imem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .wrapped    (wrapped)
  );

  always #5 clk = ~clk;

  // Behavioural instruction memory capturing every byte write.
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [8:0] a, input logic [7:0] d);
    chk({tag, "_we"}, mem_we, 1);
    chk({tag, "_addr"}, mem_addr, a);
    chk({tag, "_data"}, mem_wdata, d);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cpu_hold"}, cpu_hold, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_wrapped"}, wrapped, 0);
  endtask

  // Pulses start for one cycle; returns at the observation point of cycle T+1.
  task automatic launch(input logic [8:0] base, input logic [7:0] count);
    start      = 1'b1;
    base_addr  = base;
    word_count = count;
    step();
    start = 1'b0;
  endtask

  function automatic logic [31:0] rd_word(input logic [8:0] a);
    return {mem[a], mem[a + 9'd1], mem[a + 9'd2], mem[a + 9'd3]};
  endfunction

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    w3[0] = 32'h11223344;
    w3[1] = 32'h55667788;
    w3[2] = 32'h99AABBCC;

    step();
    step();
    chk_all_zero("rst");
    reset = 1'b0;
    step();

    // Single word at address 0
    in_valid = 1'b1;
    in_data  = 32'h24010005;
    launch(9'h000, 8'd1);
    chk("s1_busy_t1", busy, 1);
    chk("s1_rdy_t1", in_ready, 1);
    chk("s1_we_t1", mem_we, 0);
    step();
    in_valid = 1'b0;
    chk_wr("s1_b0", 9'h000, 8'h24);
    chk("s1_rdy_t2", in_ready, 0);
    step();
    chk_wr("s1_b1", 9'h001, 8'h01);
    step();
    chk_wr("s1_b2", 9'h002, 8'h00);
    step();
    chk_wr("s1_b3", 9'h003, 8'h05);
    chk("s1_done_t5", done, 0);
    step();
    chk("s1_done_t6", done, 1);
    chk("s1_busy_t6", busy, 1);
    chk("s1_we_t6", mem_we, 0);
    step();
    chk("s1_done_t7", done, 0);
    chk("s1_busy_t7", busy, 0);
    chk("s1_readback", rd_word(9'h000), 32'h24010005);

    // Back-to-back: three words, source always valid
    in_valid = 1'b1;
    in_data  = w3[0];
    launch(9'h010, 8'd3);
    for (int k = 1; k <= 16; k++) begin
      int ph;
      int wi;
      ph = (k - 1) % 5;
      wi = (k - 1) / 5;
      chk($sformatf("b2b_hold_t%0d", k), cpu_hold, 1);
      if (k == 16) begin
        chk("b2b_done_t16", done, 1);
        chk("b2b_rdy_t16", in_ready, 0);
      end else if (ph == 0) begin
        chk($sformatf("b2b_rdy_t%0d", k), in_ready, 1);
        chk($sformatf("b2b_we_t%0d", k), mem_we, 0);
        chk($sformatf("b2b_done_t%0d", k), done, 0);
      end else begin
        chk($sformatf("b2b_rdy_t%0d", k), in_ready, 0);
        chk_wr($sformatf("b2b_t%0d", k), 9'(32'h010 + 4 * wi + (ph - 1)),
               8'((w3[wi] >> (8 * (4 - ph))) & 32'hFF));
        if (ph == 1 && wi < 2) in_data = w3[wi + 1];
      end
      step();
    end
    in_valid = 1'b0;
    chk("b2b_hold_t17", cpu_hold, 0);
    chk("b2b_done_t17", done, 0);
    chk("b2b_rd0", rd_word(9'h010), 32'h11223344);
    chk("b2b_rd1", rd_word(9'h014), 32'h55667788);
    chk("b2b_rd2", rd_word(9'h018), 32'h99AABBCC);

    // Gapped source: second word arrives after 7 idle cycles
    in_valid = 1'b1;
    in_data  = 32'h13579BDF;
    launch(9'h040, 8'd2);
    chk("gap_rdy_t1", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk_wr("gap_w0b0", 9'h040, 8'h13);
    step();
    chk_wr("gap_w0b1", 9'h041, 8'h57);
    step();
    chk_wr("gap_w0b2", 9'h042, 8'h9B);
    step();
    chk_wr("gap_w0b3", 9'h043, 8'hDF);
    step();
    for (int g = 0; g < 7; g++) begin
      chk($sformatf("gap_rdy_%0d", g), in_ready, 1);
      chk($sformatf("gap_we_%0d", g), mem_we, 0);
      chk($sformatf("gap_busy_%0d", g), busy, 1);
      step();
    end
    chk("gap_rdy_hs", in_ready, 1);
    in_valid = 1'b1;
    in_data  = 32'h2468ACE0;
    step();
    in_valid = 1'b0;
    chk_wr("gap_w1b0", 9'h044, 8'h24);
    step();
    chk_wr("gap_w1b1", 9'h045, 8'h68);
    step();
    chk_wr("gap_w1b2", 9'h046, 8'hAC);
    step();
    chk_wr("gap_w1b3", 9'h047, 8'hE0);
    chk("gap_done_hs4", done, 0);
    step();
    chk("gap_done_hs5", done, 1);
    step();
    chk("gap_busy_end", busy, 0);
    chk("gap_rd0", rd_word(9'h040), 32'h13579BDF);
    chk("gap_rd1", rd_word(9'h044), 32'h2468ACE0);

    // Wrap and alignment: 0x1FE is forced down to 0x1FC
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    launch(9'h1FE, 8'd2);
    chk("wrap_rdy_t1", in_ready, 1);
    chk("wrap_flag_t1", wrapped, 0);
    step();
    in_data = 32'hCAFEF00D;
    chk_wr("wrap_b1fc", 9'h1FC, 8'hDE);
    step();
    chk_wr("wrap_b1fd", 9'h1FD, 8'hAD);
    step();
    chk_wr("wrap_b1fe", 9'h1FE, 8'hBE);
    step();
    chk_wr("wrap_b1ff", 9'h1FF, 8'hEF);
    chk("wrap_flag_t5", wrapped, 0);
    step();
    chk("wrap_flag_t6", wrapped, 1);
    chk("wrap_rdy_t6", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk_wr("wrap_b000", 9'h000, 8'hCA);
    step();
    chk_wr("wrap_b001", 9'h001, 8'hFE);
    step();
    chk_wr("wrap_b002", 9'h002, 8'hF0);
    step();
    chk_wr("wrap_b003", 9'h003, 8'h0D);
    step();
    chk("wrap_done_t11", done, 1);
    chk("wrap_flag_t11", wrapped, 1);
    step();
    chk("wrap_busy_t12", busy, 0);
    chk("wrap_flag_t12", wrapped, 1);
    chk("wrap_rd_hi", rd_word(9'h1FC), 32'hDEADBEEF);
    chk("wrap_rd_lo", rd_word(9'h000), 32'hCAFEF00D);

    // Zero-word request, which also clears the sticky wrap flag
    launch(9'h020, 8'd0);
    chk("zero_done_t1", done, 1);
    chk("zero_busy_t1", busy, 1);
    chk("zero_rdy_t1", in_ready, 0);
    chk("zero_we_t1", mem_we, 0);
    chk("zero_flag_t1", wrapped, 0);
    step();
    chk("zero_done_t2", done, 0);
    chk("zero_busy_t2", busy, 0);
    chk("zero_we_t2", mem_we, 0);

    // Reset asserted during WR2 of the first word
    in_valid = 1'b1;
    in_data  = 32'h0A0B0C0D;
    launch(9'h080, 8'd1);
    chk("rmid_rdy_t1", in_ready, 1);
    step();
    chk_wr("rmid_b0", 9'h080, 8'h0A);
    step();
    chk_wr("rmid_b1", 9'h081, 8'h0B);
    step();
    chk_wr("rmid_b2", 9'h082, 8'h0C);
    reset = 1'b1;
    #1;
    chk_all_zero("rmid_async");
    step();
    chk("rmid_wr80", 32'(written[9'h080]), 1);
    chk("rmid_wr81", 32'(written[9'h081]), 1);
    chk("rmid_wr82", 32'(written[9'h082]), 0);
    chk("rmid_wr83", 32'(written[9'h083]), 0);
    reset = 1'b0;
    step();
    launch(9'h080, 8'd1);
    chk("rnew_rdy_t1", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk_wr("rnew_b0", 9'h080, 8'h0A);
    step();
    chk_wr("rnew_b1", 9'h081, 8'h0B);
    step();
    chk_wr("rnew_b2", 9'h082, 8'h0C);
    step();
    chk_wr("rnew_b3", 9'h083, 8'h0D);
    step();
    chk("rnew_done_t6", done, 1);
    step();
    chk("rnew_busy_t7", busy, 0);
    chk("rnew_rd", rd_word(9'h080), 32'h0A0B0C0D);

    // start pulsed during WR1 of an active load is ignored
    in_valid = 1'b1;
    in_data  = 32'h01020304;
    launch(9'h0C0, 8'd1);
    step();
    in_valid = 1'b0;
    chk_wr("ign_b0", 9'h0C0, 8'h01);
    step();
    chk_wr("ign_b1", 9'h0C1, 8'h02);
    start      = 1'b1;
    base_addr  = 9'h000;
    word_count = 8'd5;
    step();
    start = 1'b0;
    chk_wr("ign_b2", 9'h0C2, 8'h03);
    step();
    chk_wr("ign_b3", 9'h0C3, 8'h04);
    step();
    chk("ign_done_t6", done, 1);
    chk("ign_busy_t6", busy, 1);
    step();
    chk("ign_busy_t7", busy, 0);
    chk("ign_rdy_t7", in_ready, 0);
    chk("ign_rd", rd_word(9'h0C0), 32'h01020304);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side companion to the instruction memory. It accepts 32-bit instruction words over a valid/ready handshake and writes each one big-endian, one byte per cycle, into the 512×8 instruction memory byte port. The byte order matches the fetch read: Mem[A] = word[31:24] through Mem[A+3] = word[7:0]. While loading, it holds the fetch stage (PC/nPC load enables) so the pipeline never fetches a partially written word.

## Interface

Parameters:
- ADDR_W, 9, byte address width of instruction memory
- CNT_W, 8, width of word_count

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high
- start  input  1  one-cycle request to begin a load; sampled only in IDLE
- base_addr  input  ADDR_W  first byte address; bits [1:0] forced to 0
- word_count  input  CNT_W  number of words to load; 0 is legal
- in_valid  input  1  in_data holds a word
- in_data  input  32  instruction word
- in_ready  output  1  loader accepts in_data this cycle
- mem_we  output  1  byte write strobe to instruction memory
- mem_addr  output  ADDR_W  byte write address
- mem_wdata  output  8  byte write data
- busy  output  1  high from the cycle after start until DONE completes
- cpu_hold  output  1  equals busy; fetch stage gates le_pc/le_npc with !cpu_hold
- done  output  1  one-cycle pulse at end of load
- wrapped  output  1  sticky; address passed 511→0 during the current load; cleared by next accepted start

## Operation

- States: IDLE, ACCEPT, WR0, WR1, WR2, WR3, DONE.
- IDLE, start=1:
  - Latch base_addr (with [1:0]=0) into the address register and word_count into the remaining register.
  - Clear wrapped.
  - Go to DONE if word_count==0, otherwise go to ACCEPT.
- IDLE, start=0: stay in IDLE. start in any other state is ignored, with no error and no restart.
- ACCEPT:
  - in_ready=1.
  - If in_valid=1: latch in_data into the word register and go to WR0.
  - If in_valid=0: stay in ACCEPT with in_ready held high.
- WRn (n=0..3):
  - mem_we=1, mem_addr=addr register, mem_wdata=word[31-8n:24-8n].
  - Address register increments modulo 2^ADDR_W.
  - On increment from 511 to 0, set wrapped.
- WR3 exit: decrement remaining. If the new value is 0, go to DONE; otherwise go to ACCEPT.
- DONE: done=1 for exactly one cycle, then IDLE.
- Arithmetic:
  - Address increments are ADDR_W-bit unsigned and wrap.
  - remaining is CNT_W-bit and never decrements below 0.
- Outputs are registered or decoded from state only. There is no combinational path from in_valid to in_ready.
- Reset mid-operation: state returns to IDLE immediately and all registers clear. Bytes already written stay in memory. A partially written word is not completed.

## Timing

- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, cpu_hold=0, done=0, wrapped=0.
- start at cycle T:
  - busy rises at T+1.
  - in_ready is high at T+1 (word_count>0).
- Per word: 1 accept cycle plus 4 write cycles. Throughput is 5 cycles/word when in_valid is held high.
- A handshake completes on any rising edge where in_valid && in_ready.
- The first byte write (WR0) occurs the cycle after the handshake.
- The last word's WR3 is at cycle C. Then DONE and done=1 are at C+1, with busy still 1. busy=0 and IDLE are at C+2.
- word_count=0, start at T: done=1 at T+1, no mem_we, back in IDLE at T+2.
- N words with in_valid always high: done pulses at T+1+5N.

## Structure

- Shared package (imem_pkg):
  - State enum for the loader.
  - IMEM_BYTES=512.
  - BYTES_PER_WORD=4.
  - Byte-lane index constants for big-endian ordering. The fetch read path uses the same constants.
- Single module, no sub-module.
- The byte-lane mux is an indexed part-select on the WR state index.

## Test plan

- Single word: base_addr=0x000, word_count=1, in_data=0x24010005 held valid.
  - mem writes are 0x24@0x000, 0x01@0x001, 0x00@0x002, 0x05@0x003 on four consecutive cycles.
  - done pulses once at T+6.
  - Readback through instr_mem at address 0 gives 0x24010005.
- Back-to-back: base_addr=0x010, word_count=3, in_valid always high.
  - 12 writes to 0x010–0x01B in order.
  - in_ready high only in the 3 ACCEPT cycles.
  - done at T+16.
  - cpu_hold high T+1..T+16.
- Gapped source: word_count=2, in_valid low for 7 cycles before the second word.
  - in_ready stays high for the whole gap.
  - No mem_we during the gap.
  - Bytes land correctly and done follows 5 cycles after the second handshake.
- Wrap and alignment: base_addr=0x1FE (forced to 0x1FC), word_count=2.
  - Writes go to 0x1FC–0x1FF, then 0x000–0x003.
  - wrapped rises on the cycle after the write to 0x1FF and stays 1 after done.
  - wrapped clears on the next start.
- Reset mid-load: assert reset during WR2 of word 0.
  - All outputs are 0 in the same cycle (asynchronous).
  - Bytes 0–1 remain written and byte 2 is not written.
  - A new start after reset release performs a full, correct load.
- Edge requests:
  - word_count=0: done at T+1, no mem_we, no in_ready.
  - start pulsed during WR1 of an active load: ignored, and the original load completes unchanged.
